data_sram_responder: RTL
========================

Name: data_sram_responder

Overview:
- Responder end of the CPU data-SRAM interface. Sits outside the CPU top and answers its en/wen/addr/wdata requests with rdata.
- Contains a byte-writable data memory, plus a small peripheral register window: LED, switch, free-running timer and scratch registers.
- Stands in for the external data memory in simulation and FPGA builds.

Parameters:
- DEPTH_LOG2, 10, log2 of data memory depth in 32-bit words (default 1024 words).
- PERIPH_BASE_HI, 16'hBFAF, value of addr[31:16] that selects the peripheral window.
- LED_WIDTH, 16, width of the LED output register.
- SW_WIDTH, 8, width of the switch input.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- resetn  input  1  synchronous, active-low reset.
- data_sram_en  input  1  request valid this cycle.
- data_sram_wen  input  4  byte write strobes; bit i writes wdata[8i+7:8i]; 0 = read.
- data_sram_addr  input  32  byte address; addr[1:0] ignored.
- data_sram_wdata  input  32  write data.
- data_sram_rdata  output  32  registered read data.
- led  output  LED_WIDTH  LED register contents.
- switch  input  SW_WIDTH  raw switch levels; sampled through a 2-flop synchronizer.

Behaviour:
- Reset (resetn=0 at a clk edge):
  - data_sram_rdata, led, timer, scratch and the synchronizer flops clear to 0.
  - Memory array is not reset; its contents are undefined.
  - A request presented during reset is dropped: no write, rdata stays 0.
- Decode:
  - addr[31:16]==PERIPH_BASE_HI selects the peripheral window; anything else selects memory.
  - Memory word index = addr[DEPTH_LOG2+1:2]. Higher bits are truncated, so addresses alias modulo depth.
- Peripheral offsets (addr[15:0]):
  - 0x0000 LED: RW; lanes beyond LED_WIDTH are ignored.
  - 0x0004 SWITCH: RO, zero-extended synchronized value.
  - 0x0008 TIMER: RW, 32-bit.
  - 0x000C SCRATCH: RW, 32-bit.
  - Other offsets read 0 and ignore writes.
- Read (en=1, wen=0): rdata updates at the next clk edge with the addressed word. Latency is exactly 1 cycle.
- Write (en=1, wen!=0): only the enabled byte lanes of the target are updated at the clk edge. rdata also loads at the same edge:
  - Default: the pre-write (old) word, i.e. read-first.
  - SRAM_WRITE_FIRST_EN: see below.
- Idle (en=0): no write; rdata holds its previous value.
- Back-to-back requests accepted every cycle; no stall or backpressure exists.
- Timer:
  - Increments by 1 every cycle, wrapping 0xFFFFFFFF->0.
  - Cycle with a timer write: the next value is the byte-merged write data with no increment; lanes not written keep the current value (not current+1).
  - A read returns the value held at the request cycle.
- Read-after-write to the same address in consecutive cycles returns the new data. No hazard exists because writes commit at the edge.
- Switch reads return the value synchronized 2 cycles earlier.

Optional Feature:
- SRAM_WRITE_FIRST_EN defined:
  - On a write cycle, rdata loads the merged post-write word: new bytes in enabled lanes, old bytes elsewhere.
  - Peripheral writes behave the same way; a timer write returns the merged written value.
- SRAM_WRITE_FIRST_EN undefined: read-first behaviour as above.
- Read-only cycles are identical in both modes.

Decomposition:
- Shared package holds:
  - peripheral offset constants: LED_OFS, SW_OFS, TIMER_OFS, SCRATCH_OFS;
  - PERIPH_BASE_HI default;
  - a byte-merge function (old word, new word, 4-bit strobe -> merged word), used for memory, timer and scratch.
- One sub-module: sram_byte_array.
  - Single-port 2^DEPTH_LOG2 x 32 array, per-lane write enables, registered read port.
  - Implements both the read-first and write-first variants.
- Top level handles decode, peripheral registers, synchronizer and the rdata mux.

Test Plan:
- Reset: hold resetn=0 for 3 cycles, drive en=1 wen=4'hF addr=0x0000_0010 wdata=0xDEADBEEF. Release, read 0x10 -> rdata is not 0xDEADBEEF; led=0; rdata=0 during reset.
- Byte lanes:
  - Write 0x11223344 to 0x0000_0020 with wen=4'hF, then 0xAABBCCDD with wen=4'b0101.
  - Read -> rdata=0x11BB33DD exactly one cycle after the read request.
- Write-mode check: write 0x55 with wen=4'b0001 to a word holding 0x11BB33DD.
  - Default: rdata=0x11BB33DD on the following cycle.
  - With SRAM_WRITE_FIRST_EN: rdata=0x11BB3355.
- Timer:
  - Write 0xFFFF_FFFE with wen=4'hF to 0xBFAF_0008.
  - Reads on the 2nd and 3rd cycles after the write return 0xFFFFFFFF then 0x00000000, showing the wrap.
- Peripherals:
  - Write 0x0001_ABCD to 0xBFAF_0000 -> led=0xABCD next cycle.
  - Set switch=8'h5A; a read of 0xBFAF_0004 issued 3+ cycles later returns 0x0000005A.
  - Read 0xBFAF_0040 -> 0.
- Aliasing / back-to-back:
  - Write 0x12345678 to 0x0000_1000 (DEPTH_LOG2=10).
  - Read 0x0000_0000 on the very next cycle -> 0x12345678.
  - Continuous en=1 reads of 0x1000 and 0x1004 return data in strict 1-cycle-lagged order.

Source files
------------

// File: rtl/data_sram_responder_pkg.sv
// Shared definitions for the data-SRAM responder.
//   - Peripheral register offsets within the peripheral window.
//   - Default upper address half that selects the peripheral window.
//   - Peripheral select enum used by the top-level decode.
//   - byte_merge(): combine an old word with new data under a 4-bit lane strobe.
//     It is shared by the memory, timer and scratch write paths.
// No ports (package).

package data_sram_responder_pkg;

  localparam logic [15:0] LED_OFS     = 16'h0000;
  localparam logic [15:0] SW_OFS      = 16'h0004;
  localparam logic [15:0] TIMER_OFS   = 16'h0008;
  localparam logic [15:0] SCRATCH_OFS = 16'h000C;

  localparam logic [15:0] PERIPH_BASE_HI_DEFAULT = 16'hBFAF;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_LED,
    SEL_SW,
    SEL_TIMER,
    SEL_SCRATCH
  } periph_sel_e;

  // Lane i of the result comes from new_word when strb[i] is set, else from old_word.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  strb);
    logic [31:0] merged;
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/data_sram_responder_if.sv
// CPU data-SRAM request/response bundle.
//   en    : request valid this cycle
//   wen   : byte write strobes (0 = read)
//   addr  : byte address (bits [1:0] ignored by the responder)
//   wdata : write data
//   rdata : registered read data returned by the responder
// Modports: master (CPU side), slave (responder side).

interface data_sram_responder_if;
  logic        en;
  logic [3:0]  wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output en, output wen, output addr, output wdata, input rdata);
  modport slave  (input en, input wen, input addr, input wdata, output rdata);
endinterface

// File: rtl/data_sram_responder_sram_byte_array.sv
// sram_byte_array: single-port 2^DEPTH_LOG2 x 32 memory with per-byte write
// enables and a registered read port.
// Build option: SRAM_WRITE_FIRST_EN -- when defined, a write cycle loads rdata
// with the merged post-write word; otherwise rdata gets the pre-write word.
// Ports:
//   clk, resetn : clock, synchronous active-low reset (clears rdata only)
//   en          : access this cycle
//   wen         : per-lane write enables (0 = read)
//   addr        : word index
//   wdata       : write data
//   rdata       : registered read data, holds when en=0

module sram_byte_array
  import data_sram_responder_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  en,
  input  logic [3:0]            wen,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [31:0] mem [DEPTH];

`ifdef SRAM_WRITE_FIRST_EN
  logic [31:0] post_word;
  assign post_word = byte_merge(mem[addr], wdata, wen);
`endif

  // The array itself is never reset; only the output register is. Writes are
  // gated by resetn so a request held during reset is dropped.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rdata <= '0;
    end else if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (wen[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
`ifdef SRAM_WRITE_FIRST_EN
      rdata <= post_word;
`else
      rdata <= mem[addr];
`endif
    end
  end

endmodule

// File: rtl/data_sram_responder.sv
// data_sram_responder: responder end of the CPU data-SRAM interface. Decodes
// each request to either the byte-writable data memory or a small peripheral
// window (LED, switch, free-running timer, scratch) and returns registered
// read data one cycle later.
// Build option: SRAM_WRITE_FIRST_EN -- write cycles return the merged
// post-write word instead of the pre-write word.
// Ports:
//   clk, resetn : clock, synchronous active-low reset
//   data_sram   : request/response bundle (slave modport)
//   led         : LED register contents
//   switch      : raw switch levels, passed through a 2-flop synchronizer

module data_sram_responder
  import data_sram_responder_pkg::*;
#(
  parameter int          DEPTH_LOG2     = 10,
  parameter logic [15:0] PERIPH_BASE_HI = PERIPH_BASE_HI_DEFAULT,
  parameter int          LED_WIDTH      = 16,
  parameter int          SW_WIDTH       = 8
) (
  input  logic                     clk,
  input  logic                     resetn,
  data_sram_responder_if.slave     data_sram,
  output logic [LED_WIDTH-1:0]     led,
  input  logic [SW_WIDTH-1:0]      switch
);

  logic                is_periph;
  logic                mem_en;
  logic                periph_wr;
  logic [15:0]         ofs;
  periph_sel_e         sel;
  logic [31:0]         periph_old;
  logic [31:0]         periph_merged;
  logic [31:0]         periph_rd_next;
  logic [31:0]         periph_rdata_q;
  logic                mem_sel_q;
  logic [31:0]         mem_rdata;
  logic [31:0]         timer;
  logic [31:0]         scratch;
  logic [SW_WIDTH-1:0] sw_meta;
  logic [SW_WIDTH-1:0] sw_sync;
  logic                unused_addr_lsbs;

  assign unused_addr_lsbs = &{1'b0, data_sram.addr[1:0]};

  assign is_periph = (data_sram.addr[31:16] == PERIPH_BASE_HI);
  assign mem_en    = data_sram.en && !is_periph;
  assign periph_wr = data_sram.en && is_periph && (data_sram.wen != 4'b0000);
  assign ofs       = {data_sram.addr[15:2], 2'b00};

  sram_byte_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_sram (
    .clk   (clk),
    .resetn(resetn),
    .en    (mem_en),
    .wen   (data_sram.wen),
    .addr  (data_sram.addr[DEPTH_LOG2+1:2]),
    .wdata (data_sram.wdata),
    .rdata (mem_rdata)
  );

  always_comb begin
    sel = SEL_NONE;
    case (ofs)
      LED_OFS:     sel = SEL_LED;
      SW_OFS:      sel = SEL_SW;
      TIMER_OFS:   sel = SEL_TIMER;
      SCRATCH_OFS: sel = SEL_SCRATCH;
      default:     sel = SEL_NONE;
    endcase
  end

  // Current value of the addressed peripheral register, zero-extended.
  always_comb begin
    periph_old = '0;
    case (sel)
      SEL_LED:     periph_old = 32'(led);
      SEL_SW:      periph_old = 32'(sw_sync);
      SEL_TIMER:   periph_old = timer;
      SEL_SCRATCH: periph_old = scratch;
      default:     periph_old = '0;
    endcase
  end

  assign periph_merged = byte_merge(periph_old, data_sram.wdata, data_sram.wen);

  // Value returned for a peripheral access. In write-first builds it mirrors
  // what the register holds after the edge (LED truncated, RO/unmapped unchanged).
  always_comb begin
    periph_rd_next = periph_old;
`ifdef SRAM_WRITE_FIRST_EN
    if (data_sram.wen != 4'b0000) begin
      case (sel)
        SEL_LED:                periph_rd_next = 32'(periph_merged[LED_WIDTH-1:0]);
        SEL_TIMER, SEL_SCRATCH: periph_rd_next = periph_merged;
        default:                ;
      endcase
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= switch;
      sw_sync <= sw_meta;
    end
  end

  // A timer write replaces the increment for that cycle; unwritten lanes keep
  // the current (not incremented) value via byte_merge.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      led     <= '0;
      timer   <= '0;
      scratch <= '0;
    end else begin
      timer <= timer + 32'd1;
      if (periph_wr) begin
        case (sel)
          SEL_LED:     led     <= periph_merged[LED_WIDTH-1:0];
          SEL_TIMER:   timer   <= periph_merged;
          SEL_SCRATCH: scratch <= periph_merged;
          default:     ;
        endcase
      end
    end
  end

  // Remember which source answered the last request so rdata holds while idle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      periph_rdata_q <= '0;
      mem_sel_q      <= 1'b0;
    end else if (data_sram.en) begin
      periph_rdata_q <= periph_rd_next;
      mem_sel_q      <= !is_periph;
    end
  end

  assign data_sram.rdata = mem_sel_q ? mem_rdata : periph_rdata_q;

endmodule
